// File: rtl/if_pc_predict_if.sv
// Fetch-side bus for the PC predictor: pipeline hold, EX-stage branch resolution,
// and the registered fetch address, prediction and flush back to the pipeline.
interface if_pc_predict_if;
  logic [5:0]  stall;
  logic        exValid;
  logic [31:0] exPC;
  logic        exTaken;
  logic [31:0] exTarget;
  logic        exPredict;
  logic [31:0] ifPC;
  logic        ce_o;
  logic        Predict_o;
  logic        flush_o;

  modport master (
    output stall, exValid, exPC, exTaken, exTarget, exPredict,
    input  ifPC, ce_o, Predict_o, flush_o
  );

  modport slave (
    input  stall, exValid, exPC, exTaken, exTarget, exPredict,
    output ifPC, ce_o, Predict_o, flush_o
  );
endinterface

// File: rtl/if_pc_predict.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit saturating counters,
// redirected by mispredicts resolved in EX.
module if_pc_predict #(
  parameter int          ENTRIES  = 16,
  parameter int          IDX_W    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  if_pc_predict_if.slave  bus
);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid   [ENTRIES];
  logic [TAG_W-1:0] tag     [ENTRIES];
  logic [31:0]      target  [ENTRIES];
  logic [1:0]       counter [ENTRIES];

  logic [31:0] pc;
  logic        ce;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             predict;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             mispredict;
  logic [31:0]      pc_next;
  logic             unused_bits;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  assign unused_bits = ^{bus.stall[5:1], pc[1:0], bus.exPC[1:0]};

  // Lookup reads the table state as it stands before this cycle's update
  assign lk_idx  = pc[IDX_W+1:2];
  assign lk_tag  = pc[31:IDX_W+2];
  assign lk_hit  = valid[lk_idx] && (tag[lk_idx] == lk_tag);
  assign predict = !rst && lk_hit && counter[lk_idx][1];

  assign ex_idx     = bus.exPC[IDX_W+1:2];
  assign ex_tag     = bus.exPC[31:IDX_W+2];
  assign ex_hit     = valid[ex_idx] && (tag[ex_idx] == ex_tag);
  assign mispredict = !rst && bus.exValid && (bus.exTaken != bus.exPredict);

  always_comb begin
    pc_next = pc + 32'd4;
    if (mispredict)
      pc_next = bus.exTaken ? bus.exTarget : bus.exPC + 32'd4;
    else if (bus.stall[0])
      pc_next = pc;
    else if (predict)
      pc_next = target[lk_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      ce <= 1'b0;
    end else begin
      pc <= pc_next;
      ce <= 1'b1;
    end
  end

  // Table update follows every resolved branch, regardless of pipeline hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]   <= 1'b0;
        tag[i]     <= '0;
        target[i]  <= '0;
        counter[i] <= 2'b01;
      end
    end else if (bus.exValid) begin
      if (ex_hit) begin
        counter[ex_idx] <= bus.exTaken ? sat_inc(counter[ex_idx]) : sat_dec(counter[ex_idx]);
        if (bus.exTaken)
          target[ex_idx] <= bus.exTarget;
      end else if (bus.exTaken) begin
        valid[ex_idx]   <= 1'b1;
        tag[ex_idx]     <= ex_tag;
        target[ex_idx]  <= bus.exTarget;
        counter[ex_idx] <= 2'b10;
      end
    end
  end

  assign bus.ifPC      = pc;
  assign bus.ce_o      = ce;
  assign bus.Predict_o = predict;
  assign bus.flush_o   = mispredict;
endmodule

// File: tb/tb_if_pc_predict.sv
// Directed bench for if_pc_predict: sequential fetch, stall, mispredict redirect,
// BTB allocation/aliasing, counter saturation, same-cycle lookup/update, wrap, reset.
module tb_if_pc_predict;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncmp = 0;
  int   nerr = 0;

  if_pc_predict_if bus ();

  if_pc_predict #(.ENTRIES(16), .IDX_W(4), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic s0, input logic v, input logic [31:0] pc,
                       input logic tk, input logic [31:0] tgt, input logic pr);
    @(negedge clk);
    bus.stall     = {5'b0, s0};
    bus.exValid   = v;
    bus.exPC      = pc;
    bus.exTaken   = tk;
    bus.exTarget  = tgt;
    bus.exPredict = pr;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Redirect fetch to (pc+4) via a not-taken mispredict of a branch at pc (no table change on miss)
  task automatic redirect_to(input logic [31:0] dest);
    drive(1'b0, 1'b1, dest - 32'd4, 1'b0, 32'h0, 1'b1);
    tick();
    chk("redirect_pc", bus.ifPC, dest);
  endtask

  initial begin
    bus.stall = 6'd0; bus.exValid = 1'b1; bus.exPC = 32'h20; bus.exTaken = 1'b1;
    bus.exTarget = 32'h100; bus.exPredict = 1'b0;
    #12;
    chk("rst_pc", bus.ifPC, 32'h0);
    chk("rst_ce", {31'b0, bus.ce_o}, 32'd0);
    chk("rst_pred", {31'b0, bus.Predict_o}, 32'd0);
    chk("rst_flush", {31'b0, bus.flush_o}, 32'd0);

    idle();
    rst = 1'b0;
    #1;
    chk("rel_pc", bus.ifPC, 32'h0);
    chk("rel_ce", {31'b0, bus.ce_o}, 32'd0);
    tick(); chk("seq_pc4", bus.ifPC, 32'h4); chk("seq_ce", {31'b0, bus.ce_o}, 32'd1);
    chk("seq_pred4", {31'b0, bus.Predict_o}, 32'd0);
    tick(); chk("seq_pc8", bus.ifPC, 32'h8);
    tick(); chk("seq_pcC", bus.ifPC, 32'hC);
    tick(); chk("seq_pc10", bus.ifPC, 32'h10);

    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick(); chk("stall1", bus.ifPC, 32'h10);
    tick(); chk("stall2", bus.ifPC, 32'h10);
    tick(); chk("stall3", bus.ifPC, 32'h10);
    idle();
    tick(); chk("unstall", bus.ifPC, 32'h14);

    // Taken mispredict under stall: redirect wins, entry 8 allocated with counter 2'b10
    drive(1'b1, 1'b1, 32'h20, 1'b1, 32'h100, 1'b0);
    chk("mp_flush", {31'b0, bus.flush_o}, 32'd1);
    tick(); chk("mp_pc", bus.ifPC, 32'h100);

    redirect_to(32'h20);
    idle();
    chk("hit_pred", {31'b0, bus.Predict_o}, 32'd1);
    chk("hit_flush", {31'b0, bus.flush_o}, 32'd0);
    tick(); chk("hit_pc", bus.ifPC, 32'h100);

    redirect_to(32'h60);
    idle();
    chk("alias_pred", {31'b0, bus.Predict_o}, 32'd0);
    tick(); chk("alias_pc", bus.ifPC, 32'h64);

    // Not-taken mispredict: counter 2'b10 -> 2'b01
    drive(1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b1);
    chk("nt_flush", {31'b0, bus.flush_o}, 32'd1);
    tick(); chk("nt_pc", bus.ifPC, 32'h24);
    redirect_to(32'h20);
    idle();
    chk("weak_pred", {31'b0, bus.Predict_o}, 32'd0);
    tick(); chk("weak_pc", bus.ifPC, 32'h24);

    // Counter 01 -> 10 -> 11 -> 11 (saturated), then 10 -> 01; target becomes 0x200
    drive(1'b0, 1'b1, 32'h20, 1'b1, 32'h200, 1'b1);
    chk("train_flush", {31'b0, bus.flush_o}, 32'd0);
    tick();
    drive(1'b0, 1'b1, 32'h20, 1'b1, 32'h200, 1'b1); tick();
    drive(1'b0, 1'b1, 32'h20, 1'b1, 32'h200, 1'b1); tick();
    chk("train_pc", bus.ifPC, 32'h30);
    drive(1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0); tick();
    drive(1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0); tick();
    redirect_to(32'h20);
    // Same-cycle update at the looked-up index: lookup sees counter 01
    drive(1'b0, 1'b1, 32'h20, 1'b1, 32'h200, 1'b1);
    chk("sat_pred", {31'b0, bus.Predict_o}, 32'd0);
    tick(); chk("sat_pc", bus.ifPC, 32'h24);
    redirect_to(32'h20);
    drive(1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
    chk("same_pred", {31'b0, bus.Predict_o}, 32'd1);
    chk("same_flush", {31'b0, bus.flush_o}, 32'd0);
    tick(); chk("same_pc", bus.ifPC, 32'h200);

    // Address wrap
    drive(1'b0, 1'b1, 32'h40, 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick(); chk("wrap_redir", bus.ifPC, 32'hFFFF_FFFC);
    idle();
    chk("wrap_pred", {31'b0, bus.Predict_o}, 32'd0);
    tick(); chk("wrap_pc", bus.ifPC, 32'h0);
    chk("wrap0_pred", {31'b0, bus.Predict_o}, 32'd0);
    tick(); chk("wrap_pc4", bus.ifPC, 32'h4);

    // Reset mid-operation with a redirect pending
    drive(1'b0, 1'b1, 32'h1C, 1'b1, 32'h300, 1'b0);
    chk("pend_flush", {31'b0, bus.flush_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_pc", bus.ifPC, 32'h0);
    chk("mrst_ce", {31'b0, bus.ce_o}, 32'd0);
    chk("mrst_flush", {31'b0, bus.flush_o}, 32'd0);
    chk("mrst_pred", {31'b0, bus.Predict_o}, 32'd0);
    tick(); chk("mrst_hold", bus.ifPC, 32'h0);
    idle();
    rst = 1'b0;
    tick(); chk("mrst_rel_pc", bus.ifPC, 32'h4);
    chk("mrst_rel_ce", {31'b0, bus.ce_o}, 32'd1);
    // Entry 8 was cleared by reset, so 0x20 no longer predicts
    redirect_to(32'h20);
    idle();
    chk("mrst_tbl", {31'b0, bus.Predict_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
